// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
//   fifo_mode_e  : read-port behaviour (registered read or first-word-fall-through)
//   DefaultWidth : default data word width
//   addr_w()     : memory address width for a given depth
package fifo_pkg;

  typedef enum logic [0:0] {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int unsigned DefaultWidth = 8;

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of sync_fifo_param.
//   master : the side that pushes and pops (drives wr_en, wdata, rd_en)
//   slave  : the FIFO (drives rdata, status flags, error pulses and count)
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = 16
) ();

  localparam int unsigned CntW = addr_w(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             rd_en;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;
  logic [CntW-1:0]  count;

  modport master (
    output wr_en, wdata, rd_en,
    input  rdata, full, empty, almost_full, almost_empty, overflow, underflow, count
  );

  modport slave (
    input  wr_en, wdata, rd_en,
    output rdata, full, empty, almost_full, almost_empty, overflow, underflow, count
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register-array RAM for the FIFO.
//   clk_i          : clock
//   rst_ni         : synchronous active-low reset (clears only the read register)
//   we_i, waddr_i, wdata_i : write port
//   re_i, raddr_i  : read port; re_i loads the read register when AsyncRead=0
//   rdata_o        : registered read data, or mem[raddr_i] directly when AsyncRead=1
module fifo_mem #(
  parameter int unsigned Width     = 8,
  parameter int unsigned Depth     = 16,
  parameter int unsigned AddrW     = 4,
  parameter bit          AsyncRead = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  // Storage is intentionally not reset.
  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  if (AsyncRead) begin : g_async_rd
    logic unused_async;
    assign unused_async = ^{rst_ni, re_i};
    assign rdata_o = mem_q[raddr_i];
  end else begin : g_sync_rd
    logic [Width-1:0] rdata_d, rdata_q;

    // Holds its value unless a read is accepted.
    always_comb begin
      rdata_d = rdata_q;
      if (re_i) begin
        rdata_d = mem_q[raddr_i];
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign rdata_o = rdata_q;
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read,
// occupancy count and programmable almost-full/almost-empty thresholds.
//   clk : clock, everything sampled on posedge
//   res : synchronous active-low reset
//   bus : slave side of sync_fifo_param_if (wr_en/wdata/rd_en in; rdata, full,
//         empty, almost_full, almost_empty, overflow, underflow, count out)
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned DEPTH    = 16,
  parameter fifo_mode_e  MODE     = FIFO_STD,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input logic              clk,
  input logic              res,
  sync_fifo_param_if.slave bus
);

  localparam int unsigned AddrW = addr_w(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfC    = CntW'(AF_LEVEL);
  localparam logic [CntW-1:0] AeC    = CntW'(AE_LEVEL);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be a power of 2 and >= 4");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "sync_fifo_param: AF_LEVEL must not exceed DEPTH");
  end
  if (AE_LEVEL >= DEPTH) begin : g_bad_ae
    $fatal(1, "sync_fifo_param: AE_LEVEL must be below DEPTH");
  end

  // Pointers carry an extra wrap bit; only the low bits address memory.
  logic [AddrW:0]  wr_ptr_d, wr_ptr_q;
  logic [AddrW:0]  rd_ptr_d, rd_ptr_q;
  logic [CntW-1:0] count_d, count_q;
  logic            full_d, full_q;
  logic            empty_d, empty_q;
  logic            afull_d, afull_q;
  logic            aempty_d, aempty_q;
  logic            ovf_d, ovf_q;
  logic            udf_d, udf_q;

  logic wr_acc, rd_acc;

  // Acceptance uses registered flags, so a full FIFO still pops on rd+wr and an
  // empty one still pushes on rd+wr.
  assign wr_acc = bus.wr_en & ~full_q;
  assign rd_acc = bus.rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + (AddrW + 1)'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + (AddrW + 1)'(1);
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    full_d   = (count_d == DepthC);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AfC);
    aempty_d = (count_d <= AeC);
    ovf_d    = bus.wr_en & full_q;
    udf_d    = bus.rd_en & empty_q;
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= (AF_LEVEL == 0);
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .Width     (WIDTH),
    .Depth     (DEPTH),
    .AddrW     (AddrW),
    .AsyncRead (MODE == FIFO_FWFT)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (res),
    .we_i    (wr_acc & res),
    .waddr_i (wr_ptr_q[AddrW-1:0]),
    .wdata_i (bus.wdata),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q[AddrW-1:0]),
    .rdata_o (bus.rdata)
  );

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic res = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) s_if ();
  sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) f_if ();

  sync_fifo_param #(
    .WIDTH(8), .DEPTH(8), .MODE(FIFO_STD), .AF_LEVEL(6), .AE_LEVEL(2)
  ) u_std (
    .clk (clk),
    .res (res),
    .bus (s_if.slave)
  );

  sync_fifo_param #(
    .WIDTH(8), .DEPTH(8), .MODE(FIFO_FWFT), .AF_LEVEL(6), .AE_LEVEL(2)
  ) u_fwft (
    .clk (clk),
    .res (res),
    .bus (f_if.slave)
  );

  // One clock on the standard-mode FIFO; outputs are sampled 1 ns after the edge.
  task automatic step(input logic wr, input logic [7:0] wd, input logic rd);
    s_if.wr_en = wr;
    s_if.wdata = wd;
    s_if.rd_en = rd;
    @(posedge clk);
    #1;
    s_if.wr_en = 1'b0;
    s_if.rd_en = 1'b0;
  endtask

  task automatic step_f(input logic wr, input logic [7:0] wd, input logic rd);
    f_if.wr_en = wr;
    f_if.wdata = wd;
    f_if.rd_en = rd;
    @(posedge clk);
    #1;
    f_if.wr_en = 1'b0;
    f_if.rd_en = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++;
    if (s_if.count !== 4'd0) begin
      n_fail++; $display("FAIL reset_count got %0d want 0", s_if.count);
    end
    n_checks++;
    if ({s_if.empty, s_if.full, s_if.almost_empty, s_if.almost_full} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_flags got e/f/ae/af=%b%b%b%b want 1010",
               s_if.empty, s_if.full, s_if.almost_empty, s_if.almost_full);
    end
    n_checks++;
    if ({s_if.overflow, s_if.underflow} !== 2'b00) begin
      n_fail++; $display("FAIL reset_pulses got %b%b want 00", s_if.overflow, s_if.underflow);
    end
    n_checks++;
    if (s_if.rdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_rdata got %h want 00", s_if.rdata);
    end
  endtask

  task automatic test_reset_mid_op;
    for (int i = 0; i < 5; i++) step(1'b1, 8'h11 + 8'(i), 1'b0);
    n_checks++;
    if (s_if.count !== 4'd5) begin
      n_fail++; $display("FAIL midop_count_before got %0d want 5", s_if.count);
    end
    // Write during the reset cycle must be dropped.
    res = 1'b0;
    step(1'b1, 8'h99, 1'b0);
    res = 1'b1;
    n_checks++;
    if ({s_if.count, s_if.empty, s_if.almost_empty} !== {4'd0, 2'b11}) begin
      n_fail++;
      $display("FAIL midop_after_reset got count=%0d e=%b ae=%b want 0 1 1",
               s_if.count, s_if.empty, s_if.almost_empty);
    end
    step(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (s_if.underflow !== 1'b1) begin
      n_fail++; $display("FAIL midop_underflow got %b want 1", s_if.underflow);
    end
    step(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (s_if.underflow !== 1'b0) begin
      n_fail++; $display("FAIL midop_underflow_clear got %b want 0", s_if.underflow);
    end
  endtask

  task automatic test_fill_overflow;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 8'(k), 1'b0);
      n_checks++;
      if ({s_if.count, s_if.almost_full, s_if.full} !== {4'(k), (k >= 6), (k == 8)}) begin
        n_fail++;
        $display("FAIL fill_%0d got count=%0d af=%b f=%b want %0d %b %b", k,
                 s_if.count, s_if.almost_full, s_if.full, k, (k >= 6), (k == 8));
      end
    end
    step(1'b1, 8'h09, 1'b0);
    n_checks++;
    if ({s_if.overflow, s_if.count} !== {1'b1, 4'd8}) begin
      n_fail++;
      $display("FAIL overflow got ovf=%b count=%0d want 1 8", s_if.overflow, s_if.count);
    end
    step(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (s_if.overflow !== 1'b0) begin
      n_fail++; $display("FAIL overflow_clear got %b want 0", s_if.overflow);
    end
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (s_if.rdata !== 8'(k)) begin
        n_fail++; $display("FAIL drain_%0d got %h want %h", k, s_if.rdata, 8'(k));
      end
    end
    n_checks++;
    if ({s_if.empty, s_if.count} !== {1'b1, 4'd0}) begin
      n_fail++; $display("FAIL drain_empty got e=%b count=%0d", s_if.empty, s_if.count);
    end
  endtask

  task automatic test_underflow;
    step(1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({s_if.underflow, s_if.rdata, s_if.count} !== {1'b1, 8'h08, 4'd0}) begin
      n_fail++;
      $display("FAIL underflow got udf=%b rdata=%h count=%0d want 1 08 0",
               s_if.underflow, s_if.rdata, s_if.count);
    end
    step(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (s_if.underflow !== 1'b0) begin
      n_fail++; $display("FAIL underflow_clear got %b want 0", s_if.underflow);
    end
  endtask

  task automatic test_simultaneous;
    for (int k = 0; k < 8; k++) step(1'b1, 8'hB0 + 8'(k), 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    n_checks++;
    if ({s_if.overflow, s_if.count, s_if.full, s_if.rdata} !== {1'b1, 4'd7, 1'b0, 8'hB0}) begin
      n_fail++;
      $display("FAIL simul_full got ovf=%b count=%0d f=%b rdata=%h want 1 7 0 b0",
               s_if.overflow, s_if.count, s_if.full, s_if.rdata);
    end
    for (int k = 1; k < 8; k++) step(1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({s_if.rdata, s_if.empty} !== {8'hB7, 1'b1}) begin
      n_fail++;
      $display("FAIL simul_full_drain got rdata=%h e=%b want b7 1", s_if.rdata, s_if.empty);
    end
    step(1'b1, 8'h55, 1'b1);
    n_checks++;
    if ({s_if.underflow, s_if.count, s_if.rdata} !== {1'b1, 4'd1, 8'hB7}) begin
      n_fail++;
      $display("FAIL simul_empty got udf=%b count=%0d rdata=%h want 1 1 b7",
               s_if.underflow, s_if.count, s_if.rdata);
    end
    step(1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({s_if.rdata, s_if.count, s_if.underflow} !== {8'h55, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL simul_empty_read got rdata=%h count=%0d udf=%b want 55 0 0",
               s_if.rdata, s_if.count, s_if.underflow);
    end
  endtask

  task automatic test_wrap;
    for (int k = 0; k < 3; k++) step(1'b1, 8'hC0 + 8'(k), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'hC3 + 8'(i), 1'b1);
      n_checks++;
      if ({s_if.rdata, s_if.count, s_if.overflow, s_if.underflow}
          !== {8'hC0 + 8'(i), 4'd3, 2'b00}) begin
        n_fail++;
        $display("FAIL wrap_%0d got rdata=%h count=%0d ovf=%b udf=%b want %h 3 0 0", i,
                 s_if.rdata, s_if.count, s_if.overflow, s_if.underflow, 8'hC0 + 8'(i));
      end
    end
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({s_if.rdata, s_if.empty} !== {8'hD6, 1'b1}) begin
      n_fail++; $display("FAIL wrap_tail got rdata=%h e=%b want d6 1", s_if.rdata, s_if.empty);
    end
  endtask

  task automatic test_fwft;
    step_f(1'b1, 8'h3C, 1'b0);
    n_checks++;
    if ({f_if.empty, f_if.rdata, f_if.count} !== {1'b0, 8'h3C, 4'd1}) begin
      n_fail++;
      $display("FAIL fwft_first got e=%b rdata=%h count=%0d want 0 3c 1",
               f_if.empty, f_if.rdata, f_if.count);
    end
    step_f(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (f_if.rdata !== 8'h3C) begin
      n_fail++; $display("FAIL fwft_hold got %h want 3c", f_if.rdata);
    end
    step_f(1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({f_if.empty, f_if.count} !== {1'b1, 4'd0}) begin
      n_fail++; $display("FAIL fwft_pop got e=%b count=%0d want 1 0", f_if.empty, f_if.count);
    end
    step_f(1'b1, 8'h41, 1'b0);
    step_f(1'b1, 8'h42, 1'b0);
    n_checks++;
    if (f_if.rdata !== 8'h41) begin
      n_fail++; $display("FAIL fwft_head got %h want 41", f_if.rdata);
    end
    step_f(1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({f_if.rdata, f_if.count} !== {8'h42, 4'd1}) begin
      n_fail++;
      $display("FAIL fwft_next got rdata=%h count=%0d want 42 1", f_if.rdata, f_if.count);
    end
  endtask

  initial begin
    s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.wdata = 8'h00;
    f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.wdata = 8'h00;
    res = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    res = 1'b1;
    test_reset();
    test_reset_mid_op();
    test_fill_overflow();
    test_underflow();
    test_simultaneous();
    test_wrap();
    test_fwft();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, fully parametrised FIFO. It is the successor to the fixed-width wr/rd FIFO used by the existing FIFO bench. It adds the following over that FIFO:
- configurable DEPTH
- a selectable read mode: standard or first-word-fall-through (FWFT)
- an occupancy count
- programmable almost_full and almost_empty thresholds

It keeps the full, empty, overflow and underflow flag semantics. It sits between a producer and a consumer in the same clock domain.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries. Must be a power of 2 and ≥4.
- MODE, FIFO_STD, read mode (FIFO_STD or FIFO_FWFT), from fifo_pkg.
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL.

Ports:
- clk  in  1  single clock. Everything is sampled on its posedge.
- res  in  1  synchronous, active-low reset.
- wr_en  in  1  write request.
- wdata  in  WIDTH  write data.
- rd_en  in  1  read (pop) request.
- rdata  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (res=0 at posedge clk):
  - wr_ptr=0, rd_ptr=0, count=0
  - empty=1, full=0, almost_empty=1
  - almost_full = (AF_LEVEL==0)
  - overflow=0, underflow=0, rdata=0
  - Memory contents are not cleared.
  - Reset mid-operation discards all contents in that one cycle; a write or read in the reset cycle is ignored.
- Pointers:
  - ADDR_W = $clog2(DEPTH). Pointers are ADDR_W+1 bits; the MSB is a wrap bit.
  - The low bits index memory and wrap DEPTH-1 → 0 naturally.
  - full and empty come from the registered count, not from pointer compare.
- Accept rules, evaluated on the current registered flags:
  - wr_acc = wr_en & ~full
  - rd_acc = rd_en & ~empty
- Simultaneous requests:
  - When full, a simultaneous rd_en+wr_en pops only; the write is rejected and overflow pulses.
  - When empty, a simultaneous rd_en+wr_en pushes only; the read is rejected and underflow pulses.
  - Otherwise both are accepted and count is unchanged.
- count_next = count + wr_acc − rd_acc. All flags are registered and derived from count_next, so they are valid in the cycle after the causing edge.
- overflow = wr_en & full, registered: high for exactly one cycle per rejected write. underflow is the same with rd_en & empty.
- FIFO_STD mode:
  - rdata updates one cycle after an accepted read, with the word at rd_ptr.
  - rdata holds its last value otherwise, including on a rejected read.
- FIFO_FWFT mode:
  - rdata presents the head word whenever empty=0, with no rd_en needed.
  - rd_acc pops and rdata shows the next word on the following cycle.
  - A word written into an empty FIFO appears on rdata 1 cycle after the write edge, together with empty falling.
  - rdata is don't-care while empty=1.
- Full-range write: DEPTH consecutive writes from empty leave full=1, count=DEPTH and almost_full=1.
- Elaboration checks (fatal error): DEPTH not a power of 2, AF_LEVEL > DEPTH, or AE_LEVEL ≥ DEPTH.

Decomposition:
- fifo_pkg holds:
  - typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT}
  - the default WIDTH constant, which replaces the `WIDTH macro
  - a function addr_w(depth) returning $clog2(depth)
- One sub-module, fifo_mem: a simple dual-port register-array RAM.
  - one write port (we, waddr, wdata)
  - one read port: registered for FIFO_STD, asynchronous for FIFO_FWFT, selected by a parameter
- Control (pointers, count, flags) stays in sync_fifo_param.

Test Plan (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2):
- Reset-mid-op: write 5 words, assert res=0 for one cycle → count=0, empty=1, almost_empty=1. A following read gives underflow=1 for one cycle.
- Fill/overflow: write 0x01..0x08 then 0x09 → full=1 after the 8th write, almost_full=1 after the 6th, overflow pulses once on 0x09. Reading back gives 0x01..0x08 in order; 0x09 is never seen.
- Underflow: read once on an empty FIFO → underflow=1 for exactly one cycle, rdata unchanged, count stays 0.
- Simultaneous at full: full, rd_en=wr_en=1 with wdata=0xAA → the pop happens, overflow=1, count=7. Simultaneous at empty: wdata=0x55 → count=1, underflow=1.
- Wrap-around: run 20 interleaved write/read pairs at count=3 → data order preserved across 2+ pointer wraps, count stays 3, no flag pulses.
- FWFT mode: write 0x3C into an empty FIFO → next cycle empty=0 and rdata=0x3C with no rd_en. Pop → empty=1 the next cycle.
